// File: rtl/acc_cpu_param.sv
// Parametrised single-issue accumulator CPU with a register file, a hardware call stack,
// conditional branches on zero/carry, I/O port instructions, HALT and sticky stack faults.
module acc_cpu_param #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 5,
  parameter int REG_N   = 8,
  parameter int STACK_D = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  output logic [PC_W-1:0]   o_pc_addr,
  input  logic [15:0]       i_instr,
  input  logic [DATA_W-1:0] i_in,
  output logic [DATA_W-1:0] o_out,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_halted,
  output logic              o_error
);
  localparam int RN_W = $clog2(REG_N);
  localparam int SP_W = $clog2(STACK_D + 1);
  localparam int SI_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_D);

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_LDR, OP_STR, OP_ADD, OP_ADC, OP_SUB, OP_AND,
    OP_OR,  OP_XOR, OP_IN,  OP_OUT, OP_JMP, OP_JZ,  OP_JC,  OP_SYS
  } op_e;

  logic [PC_W-1:0]                pc, pc_inc, pc_n;
  logic [DATA_W-1:0]              acc, acc_n, out_q;
  logic                           carry, c_n, zero, out_valid, halted, error;
  logic [SP_W-1:0]                sp;
  logic [REG_N-1:0][DATA_W-1:0]   regs;
  logic [STACK_D-1:0][PC_W-1:0]   stack;

  op_e               op;
  logic [11:0]       operand;
  logic [RN_W-1:0]   rn;
  logic [DATA_W-1:0] imm, rv;
  logic [PC_W-1:0]   target;
  logic [SI_W-1:0]   top_idx, push_idx;
  logic [DATA_W:0]   sum;
  logic              acc_we, reg_we, out_we, push, pop, halt_set, fault, exec;
  logic              unused_operand_bits;

  assign op        = op_e'(i_instr[15:12]);
  assign operand   = i_instr[11:0];
  assign rn        = operand[RN_W-1:0];
  assign imm       = operand[DATA_W-1:0];
  assign target    = operand[PC_W-1:0];
  assign rv        = regs[rn];
  assign pc_inc    = pc + PC_W'(1);
  assign top_idx   = SI_W'(sp - SP_W'(1));
  assign push_idx  = SI_W'(sp);
  assign exec      = i_ce & ~halted;
  assign unused_operand_bits = ^operand;

  always_comb begin
    pc_n     = pc_inc;
    acc_n    = acc;
    c_n      = carry;
    sum      = '0;
    acc_we   = 1'b0;
    reg_we   = 1'b0;
    out_we   = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    halt_set = 1'b0;
    fault    = 1'b0;
    case (op)
      OP_LDI: begin acc_n = imm; acc_we = 1'b1; end
      OP_LDR: begin acc_n = rv;  acc_we = 1'b1; end
      OP_STR: reg_we = 1'b1;
      OP_ADD, OP_ADC: begin
        sum    = {1'b0, acc} + {1'b0, rv} + {{DATA_W{1'b0}}, (op == OP_ADC) & carry};
        acc_n  = sum[DATA_W-1:0];
        c_n    = sum[DATA_W];
        acc_we = 1'b1;
      end
      OP_SUB: begin acc_n = acc - rv; c_n = (acc < rv); acc_we = 1'b1; end
      OP_AND: begin acc_n = acc & rv; c_n = 1'b0; acc_we = 1'b1; end
      OP_OR:  begin acc_n = acc | rv; c_n = 1'b0; acc_we = 1'b1; end
      OP_XOR: begin acc_n = acc ^ rv; c_n = 1'b0; acc_we = 1'b1; end
      OP_IN:  begin acc_n = i_in; acc_we = 1'b1; end
      OP_OUT: out_we = 1'b1;
      OP_JMP: pc_n = target;
      OP_JZ:  if (zero)  pc_n = target;
      OP_JC:  if (carry) pc_n = target;
      OP_SYS: begin
        case (operand[11:10])
          2'b00: if (sp == SP_FULL) fault = 1'b1;
                 else begin push = 1'b1; pc_n = target; end
          2'b01: if (sp == '0) fault = 1'b1;
                 else begin pop = 1'b1; pc_n = stack[top_idx]; end
          2'b10: begin halt_set = 1'b1; pc_n = pc; end
          default: ;
        endcase
      end
      default: ;
    endcase
    // a stack fault parks the core on the offending instruction
    if (fault) begin
      halt_set = 1'b1;
      pc_n     = pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc        <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      out_q     <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      error     <= 1'b0;
      sp        <= '0;
      regs      <= '0;
      stack     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (exec) begin
        pc    <= pc_n;
        carry <= c_n;
        if (acc_we) begin
          acc  <= acc_n;
          zero <= (acc_n == '0);
        end
        if (reg_we) regs[rn] <= acc;
        if (out_we) begin
          out_q     <= acc;
          out_valid <= 1'b1;
        end
        if (push) begin
          stack[push_idx] <= pc_inc;
          sp              <= sp + SP_W'(1);
        end
        if (pop)      sp     <= sp - SP_W'(1);
        if (halt_set) halted <= 1'b1;
        if (fault)    error  <= 1'b1;
      end
    end
  end

  assign o_pc_addr   = pc;
  assign o_acc       = acc;
  assign o_carry     = carry;
  assign o_zero      = zero;
  assign o_out       = out_q;
  assign o_out_valid = out_valid;
  assign o_halted    = halted;
  assign o_error     = error;
endmodule

// File: tb/tb_acc_cpu_param.sv
// Scoreboarded bench for acc_cpu_param: the driver runs a behavioural model and queues the
// expected architectural state; a monitor pops and compares after every active edge.
module tb_acc_cpu_param;
  localparam int DW = 8, PW = 5, RN = 8, SD = 4;

  logic          i_clk = 1'b0, i_rst = 1'b1, i_ce = 1'b0;
  logic [15:0]   i_instr = '0;
  logic [DW-1:0] i_in = '0;
  logic [PW-1:0] o_pc_addr;
  logic [DW-1:0] o_out, o_acc;
  logic          o_out_valid, o_carry, o_zero, o_halted, o_error;

  acc_cpu_param #(.DATA_W(DW), .PC_W(PW), .REG_N(RN), .STACK_D(SD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .o_pc_addr(o_pc_addr), .i_instr(i_instr),
    .i_in(i_in), .o_out(o_out), .o_out_valid(o_out_valid), .o_acc(o_acc), .o_carry(o_carry),
    .o_zero(o_zero), .o_halted(o_halted), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int pc, acc, c, z, h, e, ov, out;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;

  // behavioural model state
  int m_pc, m_acc, m_c, m_z, m_h, m_e, m_ov, m_out;
  int m_r[RN];
  int m_stk[$];

  task automatic m_reset();
    m_pc = 0; m_acc = 0; m_c = 0; m_z = 1; m_h = 0; m_e = 0; m_ov = 0; m_out = 0;
    foreach (m_r[i]) m_r[i] = 0;
    m_stk.delete();
  endtask

  task automatic m_exec(input logic [15:0] ins, input int inv);
    int op, opd, rn, npc, s, dmod;
    bit acc_op;
    dmod = 1 << DW;
    op  = int'(ins[15:12]);
    opd = int'(ins[11:0]);
    rn  = opd % RN;
    npc = (m_pc + 1) % (1 << PW);
    acc_op = 1'b1;
    case (op)
      1:  m_acc = opd % dmod;
      2:  m_acc = m_r[rn];
      4, 5: begin
        s = m_acc + m_r[rn] + ((op == 5) ? m_c : 0);
        m_c = (s >= dmod) ? 1 : 0;
        m_acc = s % dmod;
      end
      6: begin
        m_c = (m_acc < m_r[rn]) ? 1 : 0;
        m_acc = (m_acc - m_r[rn] + dmod) % dmod;
      end
      7:  begin m_acc = m_acc & m_r[rn]; m_c = 0; end
      8:  begin m_acc = m_acc | m_r[rn]; m_c = 0; end
      9:  begin m_acc = m_acc ^ m_r[rn]; m_c = 0; end
      10: m_acc = inv % dmod;
      default: acc_op = 1'b0;
    endcase
    case (op)
      3:  m_r[rn] = m_acc;
      11: begin m_out = m_acc; m_ov = 1; end
      12: npc = opd % (1 << PW);
      13: if (m_z == 1) npc = opd % (1 << PW);
      14: if (m_c == 1) npc = opd % (1 << PW);
      15: case (opd >> 10)
        0: if (m_stk.size() == SD) begin m_e = 1; m_h = 1; npc = m_pc; end
           else begin m_stk.push_back(npc); npc = opd % (1 << PW); end
        1: if (m_stk.size() == 0) begin m_e = 1; m_h = 1; npc = m_pc; end
           else npc = m_stk.pop_back();
        2: begin m_h = 1; npc = m_pc; end
        default: ;
      endcase
      default: ;
    endcase
    if (acc_op) m_z = (m_acc == 0) ? 1 : 0;
    m_pc = npc;
  endtask

  task automatic push_exp();
    q.push_back('{m_pc, m_acc, m_c, m_z, m_h, m_e, m_ov, m_out});
  endtask

  task automatic step(input bit rst, input bit ce, input logic [15:0] ins, input int inv);
    logic [31:0] iv;
    @(negedge i_clk);
    iv = inv;
    i_rst = rst; i_ce = ce; i_instr = ins; i_in = iv[DW-1:0];
    m_ov = 0;
    if (rst) m_reset();
    else if (ce && m_h == 0) m_exec(ins, inv);
    push_exp();
  endtask

  // reset pulse that opens and closes between two edges, with the core disabled
  task automatic pulse_rst();
    @(negedge i_clk);
    i_ce = 1'b0;
    i_rst = 1'b1;
    m_reset();
    #2;
    i_rst = 1'b0;
    push_exp();
  endtask

  task automatic run(input logic [15:0] ins);
    step(1'b0, 1'b1, ins, 0);
  endtask

  function automatic logic [15:0] enc(input int op, input int opd);
    logic [31:0] o, d;
    o = op; d = opd;
    return {o[3:0], d[11:0]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",        int'(o_pc_addr),   e.pc);
        chk("acc",       int'(o_acc),       e.acc);
        chk("carry",     int'(o_carry),     e.c);
        chk("zero",      int'(o_zero),      e.z);
        chk("halted",    int'(o_halted),    e.h);
        chk("error",     int'(o_error),     e.e);
        chk("out_valid", int'(o_out_valid), e.ov);
        chk("out",       int'(o_out),       e.out);
      end
    end
  end

  localparam int CALL = 15 * 1 + 0;

  initial begin
    logic [31:0] rv;
    int op, opd, sub;
    m_reset();
    // reset held while an ADD is presented, then release
    step(1'b1, 1'b1, enc(4, 1), 0);
    step(1'b1, 1'b1, enc(4, 1), 0);
    run(enc(0, 0));
    // arithmetic chain
    run(enc(1, 'hF0)); run(enc(3, 1)); run(enc(1, 'h20));
    run(enc(4, 1)); run(enc(5, 1)); run(enc(6, 1));
    // store then immediate reload, logic ops
    run(enc(3, 2)); run(enc(2, 2)); run(enc(7, 1)); run(enc(8, 2)); run(enc(9, 1));
    // branches
    run(enc(1, 0)); run(enc(13, 7));
    run(enc(1, 1)); run(enc(13, 3));
    run(enc(1, 'hF0)); run(enc(4, 1)); run(enc(14, 2));
    run(enc(1, 0)); run(enc(4, 0)); run(enc(14, 9));
    // call / return
    run(enc(12, 4)); run(enc(15, 10)); run(enc(15, 'h400));
    // overflow the stack
    for (int i = 0; i < 5; i++) run(enc(15, 10 + i));
    run(enc(0, 0)); run(enc(1, 3));
    pulse_rst();
    // return on empty stack
    run(enc(15, 'h400)); run(enc(0, 0));
    pulse_rst();
    // I/O and clock enable
    step(1'b0, 1'b1, enc(10, 0), 'h5A);
    run(enc(11, 0)); run(enc(0, 0));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, enc(11, 0), 0);
    step(1'b0, 1'b0, enc(1, 9), 0);
    // PC wrap and halt
    run(enc(12, 31)); run(enc(0, 0));
    run(enc(15, 'h800)); run(enc(1, 5)); run(enc(12, 3));
    pulse_rst();
    run(enc(0, 0));
    // randomized phase
    for (int n = 0; n < 600; n++) begin
      if (m_h != 0) begin
        pulse_rst();
      end else begin
        op  = $urandom_range(0, 15);
        rv  = $urandom;
        opd = int'(rv[11:0]);
        if (op == 15) begin
          sub = $urandom_range(0, 9);
          opd = opd & 'h3FF;
          if (sub >= 4 && sub <= 7) opd = opd | 'h400;
          else if (sub == 8)        opd = opd | 'h800;
          else if (sub == 9)        opd = opd | 'hC00;
        end
        step(1'b0, ($urandom_range(0, 99) < 85), enc(op, opd), int'($urandom_range(0, 255)));
      end
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge i_clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
- Parametrised successor of the accumulator CPU core: single-issue, one-instruction-per-enabled-cycle accumulator machine with generalised data width, program-counter width, register count and a hardware call stack.
- Adds conditional branches on zero/carry, carry-in arithmetic, I/O port instructions, HALT, and sticky stack-fault detection.
- Sits between an external combinational-read program memory (16-bit words) and the I/O fabric.

Parameters:
- DATA_W, 8, accumulator/register/IO width; legal 4..12.
- PC_W, 5, program counter width; legal 2..10.
- REG_N, 8, number of general registers; power of two, 2..256.
- STACK_D, 4, call-stack depth in return addresses; legal 1..16.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ce  in  1  clock enable; low freezes all state.
- o_pc_addr  out  PC_W  program memory address (current PC).
- i_instr  in  16  instruction at o_pc_addr, valid same cycle.
- i_in  in  DATA_W  input port sampled by IN.
- o_out  out  DATA_W  output port register.
- o_out_valid  out  1  one-cycle pulse when OUT executes.
- o_acc  out  DATA_W  accumulator.
- o_carry  out  1  carry flag.
- o_zero  out  1  zero flag.
- o_halted  out  1  core stopped (HALT or fault).
- o_error  out  1  sticky stack fault.

Behaviour:
- Reset: PC, acc, carry, o_out, o_out_valid, o_halted, o_error, stack pointer, all registers = 0; o_zero = 1.
- Encoding: op = instr[15:12]; operand = instr[11:0]; reg index rn = operand[log2(REG_N)-1:0]; imm = operand[DATA_W-1:0]; target = operand[PC_W-1:0].
- One instruction per rising edge with i_ce=1 and o_halted=0; default next PC = PC+1 mod 2^PC_W (wraps from all-ones to 0).
- i_ce=0 or o_halted=1: no state change, o_out_valid=0.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc<=imm.
  - 2 LDR: acc<=r[rn].
  - 3 STR: r[rn]<=acc.
  - 4 ADD: {c,acc}<=acc+r[rn].
  - 5 ADC: {c,acc}<=acc+r[rn]+c.
  - 6 SUB: acc<=acc-r[rn] mod 2^DATA_W; c<=1 iff acc<r[rn] (borrow).
  - 7 AND, 8 OR, 9 XOR with r[rn]; c<=0.
  - A IN: acc<=i_in.
  - B OUT: o_out<=acc, o_out_valid=1 for that cycle only.
  - C JMP: PC<=target.
  - D JZ: PC<=target if zero=1, else PC+1.
  - E JC: PC<=target if carry=1, else PC+1.
  - F sub-op by operand[11:10]:
    - 00 CALL: push PC+1 (wrapped), PC<=target.
    - 01 RET: pop into PC.
    - 10 HALT: o_halted<=1, PC holds.
    - 11 NOP.
- Zero flag: updated to (new acc==0) on every acc-writing op (1,2,4-A); unchanged otherwise. Carry changes only on 4-9.
- Branch flags: JZ/JC use flag values before the current edge.
- Stack faults:
  - CALL with STACK_D entries used: no push, PC holds, o_error<=1, o_halted<=1.
  - RET on empty stack: same.
  - Stack pointer never wraps.
- STR then LDR of the same register on the next cycle returns the stored value (register write visible next cycle).
- Reset asserted mid-program: immediate async clear of all state including halt/error; execution restarts at PC 0 on the first enabled edge after deassertion.
- Only reset leaves the halted state.

Test Plan:
- Reset: hold i_rst, apply instruction ADD -> PC=0, acc=0, zero=1, carry=0, halted=0; release, one edge with NOP -> PC=1.
- Arithmetic (DATA_W=8): LDI 0xF0; STR r1; LDI 0x20; ADD r1 -> acc=0x10, carry=1, zero=0. Then ADC r1 -> acc=0x01, carry=1. Then SUB r1 -> acc=0x11, carry=1.
- Branches: LDI 0; JZ 7 -> PC=7. LDI 1; JZ 3 at PC=k -> PC=k+1. JC with carry=1 from a prior ADD overflow -> taken.
- Call/stack: CALL 10 at PC=4 -> PC=10; RET -> PC=5. With STACK_D=4, five nested CALLs -> after the 5th, o_error=1, o_halted=1, PC frozen at the 5th CALL. RET on empty stack after reset -> o_error=1.
- I/O and enable: i_in=0x5A; IN; OUT -> o_out=0x5A, o_out_valid high exactly one cycle. i_ce=0 for 3 cycles -> PC/acc unchanged, no valid pulse.
- Wrap/halt: PC_W=5, NOP at address 31 -> PC=0. HALT -> PC frozen, further edges no effect; async reset mid-halt -> halted=0, PC=0.
